// File: rtl/full_adder_structural_verilog.sv
// Structural ripple-carry full adder, WIDTH bits, built from xor/and/or
// primitives. S/Cout are purely combinational; S_q/Cout_q are a registered
// copy with an asynchronous active-low clear.
module full_adder_structural_verilog #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q
);

    // One full-adder cell per bit. Each cell keeps its own carry nets and
    // pulls carry-in from the previous cell's scope, so the chain is a set
    // of distinct signals rather than one self-referencing carry vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic c_in;
        logic p;
        logic g;
        logic pc;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = Cin;
        end else begin : g_next
            assign c_in = g_cell[i-1].c_out;
        end

        xor u_prop (p, X1[i], X2[i]);
        and u_gen  (g, X1[i], X2[i]);
        xor u_sum  (S[i], p, c_in);
        and u_pc   (pc, p, c_in);
        or  u_cout (c_out, g, pc);
    end

    assign Cout = g_cell[WIDTH-1].c_out;

    // Capture the combinational result each rising edge; clear at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= S;
            Cout_q <= Cout;
        end
    end

endmodule

// File: tb/tb_full_adder_structural_verilog.sv
// Directed and random checks for full_adder_structural_verilog at WIDTH=1, 4, 8.
module tb_full_adder_structural_verilog;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // WIDTH=1 instance: clock and reset start undriven (X).
    logic clk1;
    logic rst1;
    logic run1 = 1'b0;
    logic a1, b1, ci1;
    logic s1, co1, sq1, coq1;

    // Shared clock/reset for WIDTH=4 and WIDTH=8 instances.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] a4, b4;
    logic ci4;
    logic [3:0] s4, sq4;
    logic co4, coq4;
    logic [7:0] a8, b8;
    logic ci8;
    logic [7:0] s8, sq8;
    logic co8, coq8;

    logic [8:0] exp_q[$];

    full_adder_structural_verilog #(.WIDTH(1)) dut1 (
        .clk(clk1), .rst_n(rst1), .X1(a1), .X2(b1), .Cin(ci1),
        .S(s1), .Cout(co1), .S_q(sq1), .Cout_q(coq1)
    );

    full_adder_structural_verilog #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .X1(a4), .X2(b4), .Cin(ci4),
        .S(s4), .Cout(co4), .S_q(sq4), .Cout_q(coq4)
    );

    full_adder_structural_verilog #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .X1(a8), .X2(b8), .Cin(ci8),
        .S(s8), .Cout(co8), .S_q(sq8), .Cout_q(coq8)
    );

    always #5 clk = ~clk;

    // clk1 only starts toggling once run1 is set.
    always begin
        #5;
        if (run1) clk1 = ~clk1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [2:0] v;
        logic [1:0] tt [8];
        logic [8:0] e;
        logic [8:0] got;

        // Truth table {S,Cout} indexed by {X1,X2,Cin}.
        tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

        // Exhaustive WIDTH=1 sweep, clk1/rst1 undriven.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; ci1 = v[0];
            #50;
            check($sformatf("w1_sweep_S_%0d", i), 64'(s1), 64'(tt[i][1]));
            check($sformatf("w1_sweep_Cout_%0d", i), 64'(co1), 64'(tt[i][0]));
            #50;
        end

        // Bring up WIDTH=1 clock and reset.
        clk1 = 1'b0;
        rst1 = 1'b0;
        run1 = 1'b1;
        #1;
        check("w1_reset_S_q", 64'(sq1), 64'd0);
        check("w1_reset_Cout_q", 64'(coq1), 64'd0);
        @(negedge clk1);
        rst1 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        @(posedge clk1); #1;
        @(negedge clk1);
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1;
        #1;
        check("w1_pre_edge_S_q", 64'(sq1), 64'd0);
        check("w1_pre_edge_Cout_q", 64'(coq1), 64'd0);
        @(posedge clk1); #1;
        check("w1_reg_S_q", 64'(sq1), 64'd0);
        check("w1_reg_Cout_q", 64'(coq1), 64'd1);

        // Load S_q=1, then assert reset between edges.
        @(negedge clk1);
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
        @(posedge clk1); #1;
        check("w1_load_S_q", 64'(sq1), 64'd1);
        check("w1_load_Cout_q", 64'(coq1), 64'd0);
        #1;
        rst1 = 1'b0;
        #1;
        check("w1_async_S_q", 64'(sq1), 64'd0);
        check("w1_async_Cout_q", 64'(coq1), 64'd0);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
        #1;
        check("w1_in_reset_S", 64'(s1), 64'd0);
        check("w1_in_reset_Cout", 64'(co1), 64'd1);
        @(posedge clk1); #1;
        check("w1_held_reset_S_q", 64'(sq1), 64'd0);
        check("w1_held_reset_Cout_q", 64'(coq1), 64'd0);

        // WIDTH=4 ripple cases and registered reset state.
        #1;
        check("w4_reset_S_q", 64'(sq4), 64'd0);
        check("w8_reset_S_q", 64'(sq8), 64'd0);
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
        #1;
        check("w4_ripple_S", 64'(s4), 64'h0);
        check("w4_ripple_Cout", 64'(co4), 64'd1);
        a4 = 4'hA; b4 = 4'h5; ci4 = 1'b0;
        #1;
        check("w4_alt_S", 64'(s4), 64'hF);
        check("w4_alt_Cout", 64'(co4), 64'd0);

        // WIDTH=8 random regression with scoreboard for the registered path.
        a8 = '0; b8 = '0; ci8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ci8 = 1'($urandom);
            e = 9'(a8) + 9'(b8) + 9'(ci8);
            exp_q.push_back(e);
            #1;
            check($sformatf("w8_comb_%0d", i), 64'({co8, s8}), 64'(e));
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                check("w8_scoreboard_empty", 64'd1, 64'd0);
            end else begin
                got = {coq8, sq8};
                check($sformatf("w8_reg_%0d", i), 64'(got), 64'(exp_q.pop_front()));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
